// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifq_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } ifq_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Storage for prefetched {pc, instr} pairs; head is read combinationally.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   enq,
   input  ifq_entry_t             enq_entry,
   input  logic                   deq,
   output logic                   head_valid,
   output ifq_entry_t             head_entry,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   ifq_entry_t    mem_q [DEPTH];
   ifq_entry_t    mem_d [DEPTH];

   // Callers guarantee enq never hits a full queue and deq never hits an empty one.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            mem_d[wr_ptr_q] = enq_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(enq) - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_valid = (count_q != '0);
   assign head_entry = head_valid ? mem_q[rd_ptr_q] : '0;
   assign count      = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetcher: one outstanding req/ack fetch at a time feeding a small FIFO,
// with redirect flushing the queue and discarding any in-flight word.
module ifetch_queue
   import ifq_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_pc,
   input  logic                   deq,
   output logic                   out_valid,
   output logic [INSTR_W-1:0]     out_instr,
   output logic [ADDR_W-1:0]      out_pc,
   output logic [$clog2(DEPTH):0] count,
   output logic                   imem_req,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_W-1:0]     imem_rdata
);

   localparam int CW = $clog2(DEPTH) + 1;

   ifq_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

   logic              enq;
   logic              deq_eff;
   logic [CW:0]       cnt_next;
   logic              has_room;
   logic [ADDR_W-1:0] target;
   logic [CW-1:0]     fifo_count;
   ifq_entry_t        head_entry;

   assign target   = redirect_pc & ~ADDR_W'(3);
   assign deq_eff  = deq & out_valid & ~redirect;
   assign enq      = imem_ack & (state_q == WAIT) & ~redirect;
   assign cnt_next = {1'b0, fifo_count} + (CW+1)'(enq) - (CW+1)'(deq_eff);
   assign has_room = (cnt_next < (CW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // A redirect that lands on the ack cycle re-issues at once instead of passing through DROP.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (!redirect && has_room) state_d = WAIT;
         WAIT: begin
            if (imem_ack) begin
               if (!redirect && !has_room) state_d = IDLE;
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: if (imem_ack) state_d = WAIT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_d      = req_q;
      addr_d     = addr_q;
      fetch_pc_d = fetch_pc_q;
      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               fetch_pc_d = target;
            end else if (has_room) begin
               req_d  = 1'b1;
               addr_d = fetch_pc_q;
            end
         end
         WAIT: begin
            if (imem_ack && redirect) begin
               fetch_pc_d = target;
               addr_d     = target;
            end else if (imem_ack) begin
               fetch_pc_d = addr_q + ADDR_W'(4);
               if (has_room) addr_d = addr_q + ADDR_W'(4);
               else          req_d  = 1'b0;
            end else if (redirect) begin
               fetch_pc_d = target;
            end
         end
         DROP: begin
            if (redirect) fetch_pc_d = target;
            if (imem_ack) addr_d = redirect ? target : fetch_pc_q;
         end
         default: req_d = 1'b0;
      endcase
   end

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .enq        (enq),
      .enq_entry  ('{pc: addr_q, instr: imem_rdata}),
      .deq        (deq_eff),
      .head_valid (out_valid),
      .head_entry (head_entry),
      .count      (fifo_count)
   );

   assign out_instr = head_entry.instr;
   assign out_pc    = head_entry.pc;
   assign count     = fifo_count;
   assign imem_req  = req_q;
   assign imem_addr = addr_q;

endmodule
